control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
  DW, 16, datapath data width
  RW, 4, register-select width
REQ-002 The block SHALL have these ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state changes on its rising edge
  resetn  in  1  reset, asynchronous, active-low
  Run  in  1  request to start one instruction
  Instr  in  10  {op[9:8], rx[7:4], ry[3:0]}
  Din  in  DW  immediate operand for load
  Data  out  DW  datapath immediate bus
  reg_x_num  out  RW  destination/first-source register select
  reg_y_num  out  RW  second-source register select
  AddXor  out  2  ALU select: 0 add, 1 xor
  A_in  out  1  load A from R[reg_x_num]
  G_in  out  1  load G from ALU(A, R[reg_y_num])
  G_out  out  1  write G into R[reg_x_num]
  Extern  out  1  write Data into R[reg_x_num]
  Busy  out  1  instruction in progress
  Done  out  1  one-cycle completion pulse
  Err  out  1  one-cycle illegal-instruction pulse
  icount  out  8  retired-instruction counter
REQ-003 All outputs SHALL be registered (Moore, decoded from state and IR).

Function
REQ-004 Ops SHALL be: 00 MVI (R[rx] <- Din), 01 ADD (R[rx] <- R[rx]+R[ry]), 10 XOR (R[rx] <- R[rx]^R[ry]), 11 illegal.
REQ-005 Any rx or ry > 7 SHALL be treated as illegal, regardless of op.
REQ-006 States SHALL be IDLE, LOAD, T1, T2, T3, ERR.
REQ-007 IDLE: when Run=1, Instr and Din SHALL be latched into IR/DR, and the next state SHALL be LOAD for MVI, T1 for ADD/XOR, or ERR for illegal.
REQ-008 LOAD: Extern=1, Data=DR, reg_x_num=rx, Done=1; next state IDLE.
REQ-009 T1: A_in=1, reg_x_num=rx; next state T2.
REQ-010 T2: G_in=1, reg_y_num=ry, AddXor=op-1 (00 add, 01 xor); next state T3.
REQ-011 T3: G_out=1, reg_x_num=rx, Done=1; next state IDLE.
REQ-012 ERR: Err=1, Done=1, no strobes asserted, icount unchanged; next state IDLE.
REQ-013 Latency from Run sampled to Done: MVI 1 cycle, ADD/XOR 3 cycles, illegal 1 cycle.
REQ-014 Busy SHALL be 1 in every state except IDLE.
REQ-015 Run SHALL be ignored while Busy=1; Instr/Din changes while Busy=1 SHALL NOT affect the current instruction.
REQ-016 Run held high SHALL start a new instruction in the IDLE cycle that follows Done (one idle cycle minimum between instructions).
REQ-017 At most one of A_in, G_in, G_out, Extern SHALL be 1 in any cycle.
REQ-018 When not driven by the current state, Data, AddXor and the strobes SHALL be 0, and reg_x_num/reg_y_num SHALL hold IR fields.
REQ-019 icount SHALL increment by 1 on each Done of a legal instruction, wrapping 255 -> 0.

Reset
REQ-020 resetn=0 SHALL immediately force IDLE, IR=0, DR=0, icount=0, and all outputs to 0, regardless of clk.
REQ-021 A reset in the middle of an instruction SHALL abort it with no further strobes and no Done; the first Run sampled after resetn rises SHALL start normally.

Verification
REQ-022 Run with MVI rx=1, Din=0x0002 -> next cycle Extern=1, Data=0x0002, reg_x_num=1, Done=1; icount=1.
REQ-023 Run with ADD rx=2, ry=1 -> A_in (x=2), then G_in (y=1, AddXor=0), then G_out (x=2) with Done=1, in 3 consecutive cycles.
REQ-024 Run with XOR rx=1, ry=2 -> sequence as ADD with AddXor=1 in T2; Instr toggled during T1 has no effect.
REQ-025 Run with op=11, or with rx=9 -> Err=1 and Done=1 for one cycle, no strobes, icount unchanged.
REQ-026 resetn pulsed low during T2 of an ADD -> all outputs 0 at once, no G_out and no Done; a following MVI completes correctly.
REQ-027 Run held high across 256 legal instructions -> one IDLE cycle between instructions, and icount wraps to 0.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer for a small register-file datapath (MVI/ADD/XOR).
// Latency Run->Done: MVI/illegal 1 cycle, ADD/XOR 3 cycles; Run ignored while Busy.
module control_sequencer #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          Run,
  input  logic [9:0]    Instr,
  input  logic [DW-1:0] Din,
  output logic [DW-1:0] Data,
  output logic [RW-1:0] reg_x_num,
  output logic [RW-1:0] reg_y_num,
  output logic [1:0]    AddXor,
  output logic          A_in,
  output logic          G_in,
  output logic          G_out,
  output logic          Extern,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  output logic [7:0]    icount
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [9:0]    ir, ir_nxt;
  logic [DW-1:0] dr, dr_nxt;
  logic          illegal;

  // Register indices above 7 do not exist in the register file.
  assign illegal = (Instr[9:8] == 2'b11) || Instr[7] || Instr[3];

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    dr_nxt    = dr;
    case (state)
      S_IDLE: begin
        if (Run) begin
          ir_nxt = Instr;
          dr_nxt = Din;
          if (illegal)                 state_nxt = S_ERR;
          else if (Instr[9:8] == 2'b00) state_nxt = S_LOAD;
          else                          state_nxt = S_T1;
        end
      end
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe is visible
  // during the cycle of the state it belongs to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      ir        <= '0;
      dr        <= '0;
      Data      <= '0;
      reg_x_num <= '0;
      reg_y_num <= '0;
      AddXor    <= '0;
      A_in      <= 1'b0;
      G_in      <= 1'b0;
      G_out     <= 1'b0;
      Extern    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      icount    <= '0;
    end else begin
      state     <= state_nxt;
      ir        <= ir_nxt;
      dr        <= dr_nxt;
      Data      <= (state_nxt == S_LOAD) ? dr_nxt : '0;
      reg_x_num <= RW'(ir_nxt[7:4]);
      reg_y_num <= RW'(ir_nxt[3:0]);
      AddXor    <= (state_nxt == S_T2) ? (ir_nxt[9:8] - 2'd1) : 2'd0;
      A_in      <= (state_nxt == S_T1);
      G_in      <= (state_nxt == S_T2);
      G_out     <= (state_nxt == S_T3);
      Extern    <= (state_nxt == S_LOAD);
      Busy      <= (state_nxt != S_IDLE);
      Done      <= (state_nxt == S_LOAD) || (state_nxt == S_T3) || (state_nxt == S_ERR);
      Err       <= (state_nxt == S_ERR);
      if ((state_nxt == S_LOAD) || (state_nxt == S_T3))
        icount <= icount + 8'd1;
    end
  end

endmodule
